sa_stream_wrapper_v2: RTL

//  Parametrised AXI-stream-style wrapper around SystolicArray (N rows x M cols) for the cgemm action.

---
 rtl/sa_stream_pkg.sv | 26 ++
 rtl/SystolicArray.sv | 65 ++++++
 rtl/sa_stream_fifo.sv | 47 ++++
 rtl/sa_stream_wrapper_v2.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sa_stream_pkg.sv
// Shared types and elaboration helpers for the systolic-array stream wrapper.
package sa_stream_pkg;

    localparam int DEF_DATA_WIDTH = 1024;
    localparam int DEF_N          = 16;
    localparam int DEF_M          = 15;
    localparam int DEF_AIW        = 32;

    // Beat layout at the default widths; the top rebuilds the same layout from its own parameters.
    typedef struct packed {
        logic                                               eob;
        logic                                               sob;
        logic [DEF_DATA_WIDTH-2-(DEF_N+DEF_M)*DEF_AIW-1:0]  pad;
        logic [DEF_M*DEF_AIW-1:0]                           colsB;
        logic [DEF_N*DEF_AIW-1:0]                           rowsA;
    } sa_beat_t;

    function automatic int valid_len(input int s3fdp, input int l2a, input int n);
        return s3fdp + l2a + 1 + n;
    endfunction

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/SystolicArray.sv
// Integer MAC stand-in for the generated SystolicArray: accumulates A*B outer products from SOB,
// then drains one M-word row per cycle, row 0 first, S3FDP+L2A+1 cycles after EOB_Q_o.
module SystolicArray #(
    parameter int N               = 16,
    parameter int M               = 15,
    parameter int ARITH_IN_WIDTH  = 32,
    parameter int ARITH_OUT_WIDTH = 32,
    parameter int S3FDP_PP_DEPTH  = 3,
    parameter int L2A_PP_DEPTH    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N*ARITH_IN_WIDTH-1:0]  rowsA_i,
    input  logic [M*ARITH_IN_WIDTH-1:0]  colsB_i,
    input  logic                         SOB_i,
    input  logic                         EOB_i,
    output logic [M*ARITH_OUT_WIDTH-1:0] C_o,
    output logic                         EOB_Q_o
);

    localparam int P   = S3FDP_PP_DEPTH + L2A_PP_DEPTH + 1;
    localparam int AIW = ARITH_IN_WIDTH;
    localparam int AOW = ARITH_OUT_WIDTH;

    typedef logic [N-1:0][M-1:0][AOW-1:0] mat_t;

    mat_t           acc, acc_nxt, drain;
    mat_t [P-1:0]   mp;
    logic [P-1:0]   ep;
    logic [2*AIW-1:0] prod;

    always_comb begin
        acc_nxt = acc;
        prod    = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                prod = {{AIW{1'b0}}, rowsA_i[i*AIW +: AIW]} * {{AIW{1'b0}}, colsB_i[j*AIW +: AIW]};
                acc_nxt[i][j] = (SOB_i ? '0 : acc[i][j]) + prod[AOW-1:0];
            end
        end
    end

    // Snapshots ride a P-deep pipeline so a following block can start accumulating immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mp    <= '0;
            ep    <= '0;
            drain <= '0;
        end else begin
            acc <= acc_nxt;
            for (int k = P-1; k > 0; k--) begin
                mp[k] <= mp[k-1];
                ep[k] <= ep[k-1];
            end
            mp[0] <= acc_nxt;
            ep[0] <= EOB_i;
            drain <= ep[P-1] ? mp[P-1] : mat_t'(drain >> (M*AOW));
        end
    end

    assign C_o     = drain[0];
    assign EOB_Q_o = ep[0];

endmodule

// File: rtl/sa_stream_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/count; writes while full are dropped.
module sa_stream_fifo #(
    parameter int C_WIDTH = 32,
    parameter int C_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [C_WIDTH-1:0]             wr_data,
    input  logic                           rd_en,
    output logic [C_WIDTH-1:0]             rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(C_DEPTH+1)-1:0]   count
);

    localparam int AW    = $clog2(C_DEPTH);
    localparam int CNT_W = $clog2(C_DEPTH + 1);

    logic [C_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               do_wr, do_rd;

    assign full    = (count == CNT_W'(C_DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/sa_stream_wrapper_v2.sv
// Stream wrapper around SystolicArray with credit-based input throttling so the output FIFO never overflows.
// Optional SA_STREAM_PERF_EN adds block / stall performance counters.
module sa_stream_wrapper_v2
    import sa_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 1024,
    parameter int N               = 16,
    parameter int M               = 15,
    parameter int ARITH_IN_WIDTH  = 32,
    parameter int ARITH_OUT_WIDTH = 32,
    parameter int S3FDP_PP_DEPTH  = 3,
    parameter int L2A_PP_DEPTH    = 1,
    parameter int FIFO_DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rts_i,
    output logic                  rtr_o,
    input  logic                  sow_i,
    input  logic                  eow_dma_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rts_o,
    input  logic                  rtr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o
`ifdef SA_STREAM_PERF_EN
    ,
    output logic [31:0]           perf_blocks_o,
    output logic [31:0]           perf_in_stall_o,
    output logic [31:0]           perf_out_stall_o
`endif
);

    localparam int VLEN  = valid_len(S3FDP_PP_DEPTH, L2A_PP_DEPTH, N);
    localparam int CW    = credit_width(FIFO_DEPTH);
    localparam int BW    = $clog2(N + 1);
    localparam int PAD_W = DATA_WIDTH - 2 - (N+M)*ARITH_IN_WIDTH;
    localparam int RW    = M*ARITH_OUT_WIDTH;

    if ((N+M)*ARITH_IN_WIDTH > DATA_WIDTH-2) begin : g_chk_in
        $error("sa_stream_wrapper_v2: operands do not fit in DATA_WIDTH-2");
    end
    if (RW > DATA_WIDTH) begin : g_chk_out
        $error("sa_stream_wrapper_v2: result row wider than DATA_WIDTH");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_chk_depth
        $error("sa_stream_wrapper_v2: FIFO_DEPTH must be a power of 2");
    end

    typedef struct packed {
        logic                           eob;
        logic                           sob;
        logic [PAD_W-1:0]               pad;
        logic [M*ARITH_IN_WIDTH-1:0]    cols_b;
        logic [N*ARITH_IN_WIDTH-1:0]    rows_a;
    } beat_t;

    beat_t            beat_in, sa_beat;
    logic             accept, reserve, pop, in_blk_beat, err_set;
    logic [CW-1:0]    credits, credits_nxt;
    logic             in_block, in_block_nxt, rtr_q, err_q;
    logic [BW-1:0]    blk_beats, beats_now;
    logic [VLEN-1:0]  vld_pipe;
    logic             eob_q, sa_valid;
    logic [RW-1:0]    sa_row, fifo_head;
    logic             fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

    assign beat_in = beat_t'(data_i);
    assign accept  = rts_i & rtr_q;
    assign sa_beat = accept ? beat_in : '0;

    SystolicArray #(
        .N(N), .M(M), .ARITH_IN_WIDTH(ARITH_IN_WIDTH), .ARITH_OUT_WIDTH(ARITH_OUT_WIDTH),
        .S3FDP_PP_DEPTH(S3FDP_PP_DEPTH), .L2A_PP_DEPTH(L2A_PP_DEPTH)
    ) u_sa (
        .clk(clk), .rst_n(rst_n),
        .rowsA_i(sa_beat.rows_a), .colsB_i(sa_beat.cols_b),
        .SOB_i(sa_beat.sob), .EOB_i(sa_beat.eob),
        .C_o(sa_row), .EOB_Q_o(eob_q)
    );

    // Taps cover exactly the N cycles during which the SA drains rows.
    assign sa_valid = |vld_pipe[VLEN-2 -: N];

    sa_stream_fifo #(.C_WIDTH(RW), .C_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n),
        .wr_en(sa_valid), .wr_data(sa_row),
        .rd_en(rtr_i), .rd_data(fifo_head),
        .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );

    always_comb begin
        reserve      = accept & beat_in.sob & ~in_block;
        pop          = rtr_i & ~fifo_empty;
        credits_nxt  = credits - (reserve ? CW'(N) : CW'(0)) + CW'(pop);
        in_block_nxt = in_block;
        if (accept & beat_in.eob) in_block_nxt = 1'b0;
        else if (reserve)         in_block_nxt = 1'b1;
        // Beat count saturates at N; only "too short" matters.
        beats_now = blk_beats;
        if (reserve)                     beats_now = BW'(1);
        else if (blk_beats != BW'(N))    beats_now = blk_beats + BW'(1);
        in_blk_beat = accept & (reserve | in_block);
        err_set     = (sa_valid & fifo_full)
                    | (accept & beat_in.sob & in_block)
                    | (in_blk_beat & beat_in.eob & (beats_now < BW'(N)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits   <= CW'(FIFO_DEPTH);
            in_block  <= 1'b0;
            blk_beats <= '0;
            rtr_q     <= 1'b0;
            err_q     <= 1'b0;
            vld_pipe  <= '0;
        end else begin
            credits  <= credits_nxt;
            in_block <= in_block_nxt;
            if (in_blk_beat) blk_beats <= beats_now;
            rtr_q    <= in_block_nxt | (credits_nxt >= CW'(N));
            err_q    <= err_q | err_set;
            vld_pipe <= {vld_pipe[VLEN-2:0], eob_q};
        end
    end

    assign rtr_o  = rtr_q;
    assign err_o  = err_q;
    assign rts_o  = ~fifo_empty;
    assign data_o = fifo_empty ? '0 : DATA_WIDTH'(fifo_head);

`ifdef SA_STREAM_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_blocks_o    <= '0;
            perf_in_stall_o  <= '0;
            perf_out_stall_o <= '0;
        end else begin
            perf_blocks_o    <= perf_blocks_o    + 32'(accept & beat_in.eob);
            perf_in_stall_o  <= perf_in_stall_o  + 32'(rts_i & ~rtr_q);
            perf_out_stall_o <= perf_out_stall_o + 32'(~fifo_empty & ~rtr_i);
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = ^{sow_i, eow_dma_i, beat_in.pad, sa_beat.pad, fifo_count};

endmodule
